// File: rtl/sd_spi_byte_engine_if.sv
// ---------------------------------------------------------------------------
// sd_spi_byte_engine_if
// Host-side handshake bundle for the SD-card SPI byte engine.
//
// Signals:
//    tx_data  [7:0]        byte to send, MSB first
//    tx_valid              tx_data valid (accepted when tx_valid & tx_ready)
//    tx_ready              engine can take a byte this cycle
//    rx_data  [7:0]        last byte received, held until the next one
//    rx_valid              one-cycle pulse when rx_data updates
//    clk_div  [DIV_WIDTH]  SPI half-period minus one, in clk_peri cycles
//    cs_req                request chip select active
//    busy                  byte transfer in progress
//
// Modports: master = host/controller side, slave = byte engine side.
// ---------------------------------------------------------------------------
interface sd_spi_byte_engine_if #(
   parameter int DIV_WIDTH = 8
);
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic [DIV_WIDTH-1:0] clk_div;
   logic                 cs_req;
   logic                 busy;

   modport master (
      output tx_data, tx_valid, clk_div, cs_req,
      input  tx_ready, rx_data, rx_valid, busy
   );

   modport slave (
      input  tx_data, tx_valid, clk_div, cs_req,
      output tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/sd_spi_byte_engine.sv
// ---------------------------------------------------------------------------
// sd_spi_byte_engine
// SPI mode 0 (CPOL=0, CPHA=0) byte shifter for talking to an SD card.
// One byte per handshake: MOSI is shifted out MSB first while MISO is shifted
// in, each half-period lasting (latched clk_div + 1) clk_peri cycles.
//
// Ports:
//    clk_peri   system clock, all state on its rising edge
//    reset      asynchronous, active-high reset
//    host       sd_spi_byte_engine_if.slave (tx/rx handshake, clk_div,
//               cs_req, busy)
//    sd_miso    SPI data from card
//    sd_mosi    SPI data to card (1 when not shifting)
//    sd_clk     SPI clock, idles low
//    sd_cs      active-low chip select, ~cs_req registered, updated in IDLE
//
// Parameters:
//    CLOCK_FREQUENCY  clk_peri frequency in Hz (informational only)
//    DIV_WIDTH        width of clk_div
//
// Optional feature macro: SD_SPI_BURST_EN
//    When defined, tx_ready is also raised in the last cycle of the 8th low
//    half-period so the next byte can follow with no IDLE cycle.
// ---------------------------------------------------------------------------
module sd_spi_byte_engine #(
   parameter int CLOCK_FREQUENCY = 16000000,
   parameter int DIV_WIDTH       = 8
) (
   input  logic                       clk_peri,
   input  logic                       reset,
   sd_spi_byte_engine_if.slave        host,
   input  logic                       sd_miso,
   output logic                       sd_mosi,
   output logic                       sd_clk,
   output logic                       sd_cs
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

   state_t               state;
   logic [DIV_WIDTH-1:0] div_lat;
   logic [DIV_WIDTH-1:0] cnt;
   logic [2:0]           bit_cnt;
   logic [7:0]           tx_shift;
   logic [7:0]           rx_shift;
   logic                 accept;
   logic                 half_end;

`ifdef SD_SPI_BURST_EN
   logic                 pend_valid;
   logic [7:0]           pend_data;
   logic [DIV_WIDTH-1:0] pend_div;
`endif

   // The clock frequency is kept only as documentation for integrators.
   logic unused_cfg;
   assign unused_cfg = ^CLOCK_FREQUENCY;

   assign accept   = host.tx_valid & host.tx_ready;
   assign half_end = (cnt == div_lat);

   // Single FSM: cnt times each half-period, the low half always comes first,
   // MISO is captured on the rise and the next MOSI bit is presented on the
   // fall. The 8th fall finishes the byte with sd_clk already back low.
   always_ff @(posedge clk_peri or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         sd_clk        <= 1'b0;
         sd_mosi       <= 1'b1;
         sd_cs         <= 1'b1;
         host.rx_data  <= 8'h00;
         host.rx_valid <= 1'b0;
         host.busy     <= 1'b0;
         host.tx_ready <= 1'b0;
         div_lat       <= '0;
         cnt           <= '0;
         bit_cnt       <= 3'd0;
         tx_shift      <= 8'h00;
         rx_shift      <= 8'h00;
`ifdef SD_SPI_BURST_EN
         pend_valid    <= 1'b0;
         pend_data     <= 8'h00;
         pend_div      <= '0;
`endif
      end else begin
         host.rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               // Chip select only tracks cs_req here, so a change made mid-byte
               // lands on the first IDLE cycle, and a request made together
               // with an accept takes effect on the accepting edge.
               sd_cs   <= ~host.cs_req;
               sd_clk  <= 1'b0;
               sd_mosi <= 1'b1;
               if (accept) begin
                  state         <= SHIFT;
                  tx_shift      <= host.tx_data;
                  sd_mosi       <= host.tx_data[7];
                  div_lat       <= host.clk_div;
                  cnt           <= '0;
                  bit_cnt       <= 3'd0;
                  host.busy     <= 1'b1;
                  host.tx_ready <= 1'b0;
               end else begin
                  host.busy     <= 1'b0;
                  host.tx_ready <= 1'b1;
               end
            end

            SHIFT: begin
               host.tx_ready <= 1'b0;
               if (!half_end) begin
                  cnt <= cnt + DIV_ONE;
`ifdef SD_SPI_BURST_EN
                  // Next cycle is the last one of the 8th low half-period.
                  if (!sd_clk && (bit_cnt == 3'd7) && ((cnt + DIV_ONE) == div_lat))
                     host.tx_ready <= 1'b1;
`endif
               end else if (!sd_clk) begin
                  cnt      <= '0;
                  sd_clk   <= 1'b1;
                  rx_shift <= {rx_shift[6:0], sd_miso};
               end else begin
                  cnt    <= '0;
                  sd_clk <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     host.rx_data  <= rx_shift;
                     host.rx_valid <= 1'b1;
`ifdef SD_SPI_BURST_EN
                     if (pend_valid) begin
                        // Chain straight into the queued byte; its first low
                        // half-period starts right now.
                        pend_valid <= 1'b0;
                        tx_shift   <= pend_data;
                        sd_mosi    <= pend_data[7];
                        div_lat    <= pend_div;
                        bit_cnt    <= 3'd0;
                     end else begin
                        state         <= IDLE;
                        sd_mosi       <= 1'b1;
                        host.busy     <= 1'b0;
                        host.tx_ready <= 1'b1;
                     end
`else
                     state         <= IDLE;
                     sd_mosi       <= 1'b1;
                     host.busy     <= 1'b0;
                     host.tx_ready <= 1'b1;
`endif
                  end else begin
                     bit_cnt  <= bit_cnt + 3'd1;
                     sd_mosi  <= tx_shift[6];
                     tx_shift <= {tx_shift[6:0], 1'b0};
`ifdef SD_SPI_BURST_EN
                     // With a one-cycle half-period the 8th low half-period
                     // is entirely the next cycle.
                     if ((bit_cnt == 3'd6) && (div_lat == '0))
                        host.tx_ready <= 1'b1;
`endif
                  end
               end
`ifdef SD_SPI_BURST_EN
               // Burst accept: park the byte and divider until the 8th fall.
               if (accept) begin
                  pend_valid    <= 1'b1;
                  pend_data     <= host.tx_data;
                  pend_div      <= host.clk_div;
                  host.tx_ready <= 1'b0;
               end
`endif
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_byte_engine
// Directed bench for sd_spi_byte_engine: a table of single-byte vectors plus
// hand-written sequences for chip-select deferral, reset mid-byte, divider
// change mid-byte and back-to-back bytes (with or without SD_SPI_BURST_EN).
// ---------------------------------------------------------------------------
module tb_sd_spi_byte_engine;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] div;
      bit         lb;
      logic [7:0] card;
      logic [7:0] exp_rx;
   } vec_t;

`ifdef SD_SPI_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic clk_peri;
   logic reset;
   logic sd_miso;
   logic sd_mosi;
   logic sd_clk;
   logic sd_cs;

   sd_spi_byte_engine_if #(.DIV_WIDTH(8)) bus ();

   sd_spi_byte_engine #(
      .CLOCK_FREQUENCY(16000000),
      .DIV_WIDTH(8)
   ) dut (
      .clk_peri(clk_peri),
      .reset(reset),
      .host(bus),
      .sd_miso(sd_miso),
      .sd_mosi(sd_mosi),
      .sd_clk(sd_clk),
      .sd_cs(sd_cs)
   );

   initial clk_peri = 1'b0;
   always #5 clk_peri = ~clk_peri;

   int         total = 0;
   int         bad   = 0;

   // Results of the most recent applyStimulus call.
   int         last_lat;
   int         last_pulses;
   logic [7:0] last_cap;
   logic [7:0] last_rx;
   logic       last_clk_at_done;
   logic       last_got;
   logic       cs_low_seen;
   logic       cs_at_accept;

   vec_t       vecs[5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_peri);
      #1;
   endtask

   // Sends one byte and follows it cycle by cycle until rx_valid. A card model
   // drives MISO (loopback of MOSI, or a fixed byte MSB first, changing after
   // each sd_clk fall). Optional mid-byte events: divider change, cs_req rise,
   // and a tx_valid pulse that must be ignored.
   task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] div, input bit lb,
                                input logic [7:0] card, input int chg_fall, input logic [7:0] chg_div,
                                input int cs_fall, input int junk_k);
      int   waitc;
      int   k;
      int   falls;
      int   budget;
      logic prev;
      waitc = 0;
      while (!bus.tx_ready && waitc < 64) begin
         tick();
         waitc++;
      end
      if (!bus.tx_ready) checkOutput("ready_timeout", 32'(bus.tx_ready), 32'd1);
      bus.tx_data  = tx;
      bus.clk_div  = div;
      bus.tx_valid = 1'b1;
      sd_miso      = lb ? tx[7] : card[7];
      tick();
      bus.tx_valid = 1'b0;
      bus.tx_data  = ~tx;
      k = 0;
      falls = 0;
      prev = 1'b0;
      last_pulses = 0;
      last_cap = 8'h00;
      last_got = 1'b0;
      last_lat = -1;
      cs_low_seen = 1'b0;
      cs_at_accept = sd_cs;
      budget = 16 * (int'(div) + 1) + 8;
      while (!last_got && k <= budget) begin
         if (sd_clk && !prev) begin
            last_pulses++;
            last_cap = {last_cap[6:0], sd_mosi};
         end
         if (!sd_clk && prev) falls++;
         prev = sd_clk;
         if (!sd_cs) cs_low_seen = 1'b1;
         if (falls == chg_fall) bus.clk_div = chg_div;
         if (falls == cs_fall) bus.cs_req = 1'b1;
         if (k == junk_k) begin
            bus.tx_data  = 8'h00;
            bus.tx_valid = 1'b1;
         end else if (k == junk_k + 1) begin
            bus.tx_valid = 1'b0;
         end
         sd_miso = lb ? sd_mosi : ((falls < 8) ? card[3'(7 - falls)] : 1'b1);
         if (bus.rx_valid) begin
            last_got = 1'b1;
            last_lat = k;
            last_rx = bus.rx_data;
            last_clk_at_done = sd_clk;
         end else begin
            tick();
            k++;
         end
      end
      if (!last_got) checkOutput("done_timeout", 32'(last_got), 32'd1);
   endtask

   // Checks the byte just finished, then one cycle later that the pulse has
   // ended, rx_data holds and MOSI is back high.
   task automatic checkByte(input logic [7:0] tx, input logic [7:0] div, input logic [7:0] exp_rx);
      checkOutput("rx_data", 32'(last_rx), 32'(exp_rx));
      checkOutput("latency", 32'(last_lat), 32'(16 * (int'(div) + 1)));
      checkOutput("sclk_pulses", 32'(last_pulses), 32'd8);
      checkOutput("mosi_bits", 32'(last_cap), 32'(tx));
      checkOutput("sclk_low_at_done", 32'(last_clk_at_done), 32'd0);
      tick();
      checkOutput("rx_valid_one_cycle", 32'(bus.rx_valid), 32'd0);
      checkOutput("rx_data_hold", 32'(bus.rx_data), 32'(exp_rx));
      checkOutput("mosi_idle", 32'(sd_mosi), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         k;
      int         falls;
      logic       prev;
      logic       rv_seen;
      int         nacc;
      int         nrv;
      int         rises;
      int         idle;
      int         rvt[2];
      logic [7:0] rvd[2];
      logic       will;

      vecs[0] = '{tx: 8'hA5, div: 8'd0,  lb: 1'b1, card: 8'h00, exp_rx: 8'hA5};
      vecs[1] = '{tx: 8'hFF, div: 8'd19, lb: 1'b0, card: 8'h00, exp_rx: 8'h00};
      vecs[2] = '{tx: 8'h3C, div: 8'd2,  lb: 1'b0, card: 8'h96, exp_rx: 8'h96};
      vecs[3] = '{tx: 8'h00, div: 8'd1,  lb: 1'b0, card: 8'hFF, exp_rx: 8'hFF};
      vecs[4] = '{tx: 8'h5A, div: 8'd0,  lb: 1'b1, card: 8'h00, exp_rx: 8'h5A};

      reset        = 1'b1;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      bus.clk_div  = 8'd0;
      bus.cs_req   = 1'b0;
      sd_miso      = 1'b0;
      #12;

      // Values forced while reset is held.
      checkOutput("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_sd_clk", 32'(sd_clk), 32'd0);
      checkOutput("rst_sd_mosi", 32'(sd_mosi), 32'd1);
      checkOutput("rst_sd_cs", 32'(sd_cs), 32'd1);
      checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
      checkOutput("rst_rx_valid", 32'(bus.rx_valid), 32'd0);

      @(posedge clk_peri);
      #1;
      reset = 1'b0;
      checkOutput("ready_before_edge", 32'(bus.tx_ready), 32'd0);
      tick();
      checkOutput("ready_after_edge", 32'(bus.tx_ready), 32'd1);
      checkOutput("idle_busy", 32'(bus.busy), 32'd0);

      // Table of single bytes.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].tx, vecs[i].div, vecs[i].lb, vecs[i].card, -1, 8'd0, -1, -5);
         checkByte(vecs[i].tx, vecs[i].div, vecs[i].exp_rx);
      end

      // Divider change 0->5 after bit 2 must not affect the byte in flight;
      // the next byte runs with the new half-period and ignores a stray
      // tx_valid pulse while busy.
      applyStimulus(8'hC3, 8'd0, 1'b1, 8'h00, 2, 8'd5, -1, -5);
      checkByte(8'hC3, 8'd0, 8'hC3);
      applyStimulus(8'h81, 8'd5, 1'b1, 8'h00, -1, 8'd0, -1, 10);
      checkByte(8'h81, 8'd5, 8'h81);
      tick();
      tick();
      checkOutput("stray_valid_ignored", 32'(bus.busy), 32'd0);

      // Chip-select request raised mid-byte is deferred to the first IDLE cycle.
      applyStimulus(8'h6E, 8'd2, 1'b1, 8'h00, -1, 8'd0, 3, -5);
      checkOutput("cs_deferred_in_byte", 32'(cs_low_seen), 32'd0);
      checkOutput("cs_high_at_done", 32'(sd_cs), 32'd1);
      checkByte(8'h6E, 8'd2, 8'h6E);
      checkOutput("cs_low_after_idle", 32'(sd_cs), 32'd0);

      // cs_req rising together with an accept: sd_cs falls on the accept edge.
      bus.cs_req = 1'b0;
      tick();
      tick();
      checkOutput("cs_released", 32'(sd_cs), 32'd1);
      bus.cs_req = 1'b1;
      applyStimulus(8'h12, 8'd1, 1'b1, 8'h00, -1, 8'd0, -1, -5);
      checkOutput("cs_on_accept", 32'(cs_at_accept), 32'd0);
      checkByte(8'h12, 8'd1, 8'h12);

      // Reset during bit 3 aborts the byte with no rx_valid.
      bus.clk_div  = 8'd3;
      bus.tx_data  = 8'h99;
      bus.tx_valid = 1'b1;
      sd_miso      = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      falls = 0;
      prev = sd_clk;
      k = 0;
      rv_seen = 1'b0;
      while (falls < 3 && k < 100) begin
         if (!sd_clk && prev) falls++;
         prev = sd_clk;
         if (bus.rx_valid) rv_seen = 1'b1;
         if (falls < 3) begin
            tick();
            k++;
         end
      end
      checkOutput("reach_bit3", 32'(falls), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_sd_clk", 32'(sd_clk), 32'd0);
      checkOutput("abort_sd_mosi", 32'(sd_mosi), 32'd1);
      checkOutput("abort_sd_cs", 32'(sd_cs), 32'd1);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(posedge clk_peri);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (bus.rx_valid) rv_seen = 1'b1;
         tick();
      end
      checkOutput("abort_no_rx_valid", 32'(rv_seen), 32'd0);
      applyStimulus(8'h3A, 8'd1, 1'b1, 8'h00, -1, 8'd0, -1, -5);
      checkByte(8'h3A, 8'd1, 8'h3A);

      // Back-to-back 0x40 then 0x00 with tx_valid held, clk_div=0.
      bus.clk_div  = 8'd0;
      bus.tx_data  = 8'h40;
      bus.tx_valid = 1'b1;
      nacc = 0;
      nrv = 0;
      rises = 0;
      idle = 0;
      k = 0;
      rvt[0] = 0;
      rvt[1] = 0;
      rvd[0] = 8'h00;
      rvd[1] = 8'h00;
      prev = sd_clk;
      while (nrv < 2 && k < 200) begin
         will = bus.tx_valid && bus.tx_ready;
         sd_miso = sd_mosi;
         if (sd_clk && !prev) rises++;
         prev = sd_clk;
         if (bus.rx_valid) begin
            rvt[nrv] = k;
            rvd[nrv] = bus.rx_data;
            nrv++;
         end
         if (nacc >= 1 && nrv < 2 && !bus.busy) idle++;
         tick();
         k++;
         if (will) begin
            nacc++;
            if (nacc == 1) bus.tx_data = 8'h00;
            else bus.tx_valid = 1'b0;
         end
      end
      bus.tx_valid = 1'b0;
      checkOutput("b2b_rx_count", 32'(nrv), 32'd2);
      checkOutput("b2b_rx0", 32'(rvd[0]), 32'h40);
      checkOutput("b2b_rx1", 32'(rvd[1]), 32'h00);
      checkOutput("b2b_spacing", 32'(rvt[1] - rvt[0]), BURST ? 32'd16 : 32'd17);
      checkOutput("b2b_idle_cycles", 32'(idle), BURST ? 32'd0 : 32'd1);
      checkOutput("b2b_sclk_pulses", 32'(rises), 32'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_spi_byte_engine.md
SD_SPI_BYTE_ENGINE -- requirements
Module: sd_spi_byte_engine

Interface
REQ-001 SHALL provide parameter CLOCK_FREQUENCY, default 16000000, the clk_peri frequency in Hz (documentation only; no logic depends on it).
REQ-002 SHALL provide parameter DIV_WIDTH, default 8, the width of clk_div.
REQ-003 clk_peri  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tx_data  input  8  byte to transmit, MSB first.
REQ-006 tx_valid  input  1  tx_data valid; a byte is accepted when tx_valid & tx_ready.
REQ-007 tx_ready  output  1  engine can accept a byte this cycle.
REQ-008 rx_data  output  8  last received byte; holds until the next completion.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 clk_div  input  DIV_WIDTH  SPI half-period minus one, in clk_peri cycles.
REQ-011 cs_req  input  1  request chip select active.
REQ-012 busy  output  1  byte transfer in progress.
REQ-013 sd_miso  input  1  SPI data from card.
REQ-014 sd_mosi  output  1  SPI data to card.
REQ-015 sd_clk  output  1  SPI clock.
REQ-016 sd_cs  output  1  active-low chip select.

Function
REQ-017 SHALL implement SPI mode 0 (CPOL=0, CPHA=0): sd_clk idles low, sd_miso is sampled on sd_clk rise, and sd_mosi changes on sd_clk fall.
REQ-018 SHALL implement states IDLE and SHIFT with these transitions:
  - IDLE->SHIFT on accept;
  - SHIFT->IDLE after the 8th falling half-period.
REQ-019 SHALL assert tx_ready=1 and busy=0 in IDLE, and tx_ready=0 and busy=1 in SHIFT (except as REQ-031 allows).
REQ-020 On accept, SHALL latch tx_data and clk_div, drive sd_mosi=tx_data[7] from the next cycle, and keep sd_clk low; clk_div changes mid-byte SHALL have no effect.
REQ-021 Each half-period SHALL last latched clk_div+1 clk_peri cycles:
  - clk_div=0 gives sd_clk = clk_peri/2;
  - all-ones gives 2^DIV_WIDTH cycles per half-period.
REQ-022 Per bit, the low half-period SHALL precede the high half-period:
  - sample sd_miso into the LSB of the receive shift register on the rising edge;
  - shift the next bit onto sd_mosi on the falling edge.
REQ-023 rx_valid SHALL pulse and rx_data SHALL update exactly 16*(clk_div+1) cycles after the accepting edge, with sd_clk low at that point.
REQ-024 sd_mosi SHALL be 1 whenever not in SHIFT.
REQ-025 sd_cs SHALL follow ~cs_req registered one cycle, and SHALL update only in IDLE; a cs_req change during SHIFT SHALL be deferred until the first IDLE cycle.
REQ-026 If an accept and a cs_req assertion occur in the same IDLE cycle, sd_cs SHALL fall on the same edge the byte is accepted.
REQ-027 tx_valid without tx_ready SHALL be ignored, and tx_data SHALL not be sampled.

Reset
REQ-028 While reset=1, SHALL asynchronously force the following values:
  - state=IDLE, sd_clk=0, sd_mosi=1, sd_cs=1;
  - rx_data=0, rx_valid=0, busy=0;
  - tx_ready=0.
REQ-029 tx_ready SHALL go to 1 on the first clk_peri edge after reset deasserts.
REQ-030 Reset during SHIFT SHALL abort the byte without producing an rx_valid pulse.

Configuration
REQ-031 With SD_SPI_BURST_EN defined:
  - tx_ready SHALL also be 1 in the final cycle of the 8th low half-period;
  - an accept there SHALL load the next byte back-to-back, with no IDLE cycle and no sd_clk gap beyond one low half-period;
  - rx_valid for the previous byte SHALL still pulse.
REQ-032 Without SD_SPI_BURST_EN, tx_ready SHALL be 1 only in IDLE, giving at least one IDLE cycle between bytes.

Verification
REQ-033 Single byte: clk_div=0, tx_data=0xA5, miso loopback from mosi -> 8 sd_clk pulses, mosi bits 1,0,1,0,0,1,0,1, rx_data=0xA5 and rx_valid pulse 16 cycles after accept.
REQ-034 Slow init rate: clk_div=19, tx_data=0xFF, miso=0 -> sd_clk 400 kHz at 16 MHz, rx_data=0x00 after 320 cycles.
REQ-035 Chip select deferral: cs_req 0->1 mid-byte -> sd_cs stays 1 until the cycle after the byte completes, then 0; rx_data remains correct.
REQ-036 Reset mid-byte: reset at bit 3 -> sd_clk=0, sd_mosi=1, sd_cs=1 immediately, no rx_valid pulse, and the next byte completes normally.
REQ-037 Back-to-back: two bytes 0x40, 0x00 with tx_valid held -> with SD_SPI_BURST_EN, 16 contiguous sd_clk pulses and 2 rx_valid pulses 16*(clk_div+1) apart; without the macro, at least one IDLE cycle between bytes.
REQ-038 clk_div change during a byte: 0->5 at bit 2 -> the current byte keeps a half-period of 1, and the next byte uses a half-period of 6.
